// File: rtl/simd_alu_pipe.sv
// Two-stage SIMD add/sub datapath: lane widths 8/16/32/64, signed or unsigned,
// wrap or saturate, valid/ready on both sides, sticky per-byte over/underflow.
module simd_alu_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int NBYTE      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [1:0]            in_mode,
  input  logic                  in_sub,
  input  logic                  in_signed,
  input  logic                  in_sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NBYTE-1:0]      out_ovf,
  output logic [NBYTE-1:0]      out_udf,
  input  logic                  clr_sticky,
  output logic [NBYTE-1:0]      sticky_ovf,
  output logic [NBYTE-1:0]      sticky_udf
);

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_a;
  logic [DATA_WIDTH-1:0] r_s1_b;
  logic [1:0]            r_s1_mode;
  logic                  r_s1_sub;
  logic                  r_s1_signed;
  logic                  r_s1_sat;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_s2_data;
  logic [NBYTE-1:0]      r_s2_ovf;
  logic [NBYTE-1:0]      r_s2_udf;
  logic [NBYTE-1:0]      r_sticky_ovf;
  logic [NBYTE-1:0]      r_sticky_udf;

  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic                  w_out_hs;
  logic [DATA_WIDTH-1:0] w_res;
  logic [NBYTE-1:0]      w_ovf;
  logic [NBYTE-1:0]      w_udf;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_hs   = r_s2_valid && out_ready;
  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign out_ovf    = r_s2_ovf;
  assign out_udf    = r_s2_udf;
  assign sticky_ovf = r_sticky_ovf;
  assign sticky_udf = r_sticky_udf;

  // Byte-serial carry chain restarted at each lane boundary; flags resolved at the lane's top byte.
  always_comb begin
    logic                  c;
    logic                  v;
    logic                  lo;
    logic                  lu;
    logic [8:0]            s;
    logic [7:0]            bx;
    logic [DATA_WIDTH-1:0] wrap;
    logic [NBYTE-1:0]      end_ovf;
    logic [NBYTE-1:0]      end_udf;
    int                    lmask;
    c       = 1'b0;
    v       = 1'b0;
    lo      = 1'b0;
    lu      = 1'b0;
    s       = 9'd0;
    bx      = 8'd0;
    wrap    = '0;
    end_ovf = '0;
    end_udf = '0;
    w_res   = '0;
    w_ovf   = '0;
    w_udf   = '0;
    lmask   = (32'sd1 << r_s1_mode) - 32'sd1;
    for (int i = 0; i < NBYTE; i++) begin
      bx = r_s1_b[8*i +: 8] ^ {8{r_s1_sub}};
      c  = ((i & lmask) == 32'sd0) ? r_s1_sub : c;
      s  = {1'b0, r_s1_a[8*i +: 8]} + {1'b0, bx} + {8'd0, c};
      wrap[8*i +: 8] = s[7:0];
      c  = s[8];
      if ((i & lmask) == lmask) begin
        v = (r_s1_a[8*i+7] == bx[7]) && (s[7] != bx[7]);
        if (r_s1_signed) begin
          end_ovf[i] = v & ~bx[7];
          end_udf[i] = v & bx[7];
        end else if (r_s1_sub) begin
          end_ovf[i] = 1'b0;
          end_udf[i] = ~s[8];
        end else begin
          end_ovf[i] = s[8];
          end_udf[i] = 1'b0;
        end
      end else begin
        v = 1'b0;
      end
    end
    // Walk downward so each byte sees the flags of the lane top it belongs to.
    for (int i = NBYTE - 1; i >= 0; i--) begin
      lo       = ((i & lmask) == lmask) ? end_ovf[i] : lo;
      lu       = ((i & lmask) == lmask) ? end_udf[i] : lu;
      w_ovf[i] = lo;
      w_udf[i] = lu;
      if (r_s1_sat && lo) begin
        w_res[8*i +: 8] = (r_s1_signed && ((i & lmask) == lmask)) ? 8'h7F : 8'hFF;
      end else if (r_s1_sat && lu) begin
        w_res[8*i +: 8] = (r_s1_signed && ((i & lmask) == lmask)) ? 8'h80 : 8'h00;
      end else begin
        w_res[8*i +: 8] = wrap[8*i +: 8];
      end
    end
  end

  // Pipeline stages and sticky status; each stage holds while its successor stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_mode    <= 2'd0;
      r_s1_sub     <= 1'b0;
      r_s1_signed  <= 1'b0;
      r_s1_sat     <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s2_data    <= '0;
      r_s2_ovf     <= '0;
      r_s2_udf     <= '0;
      r_sticky_ovf <= '0;
      r_sticky_udf <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_a      <= in_a;
          r_s1_b      <= in_b;
          r_s1_mode   <= in_mode;
          r_s1_sub    <= in_sub;
          r_s1_signed <= in_signed;
          r_s1_sat    <= in_sat;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_res;
          r_s2_ovf  <= w_ovf;
          r_s2_udf  <= w_udf;
        end
      end
      if (clr_sticky) begin
        r_sticky_ovf <= w_out_hs ? r_s2_ovf : '0;
        r_sticky_udf <= w_out_hs ? r_s2_udf : '0;
      end else if (w_out_hs) begin
        r_sticky_ovf <= r_sticky_ovf | r_s2_ovf;
        r_sticky_udf <= r_sticky_udf | r_s2_udf;
      end
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe: a lane-level arithmetic reference model
// predicts every accepted beat; directed scenarios add explicit checks.
module tb_simd_alu_pipe;

  localparam int DW = 256;
  localparam int NB = DW / 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NB-1:0] ovf;
    logic [NB-1:0] udf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [1:0]    in_mode;
  logic          in_sub;
  logic          in_signed;
  logic          in_sat;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [NB-1:0] out_ovf;
  logic [NB-1:0] out_udf;
  logic          clr_sticky;
  logic [NB-1:0] sticky_ovf;
  logic [NB-1:0] sticky_udf;

  exp_t sb[$];
  int   n_tests;
  int   n_fail;

  simd_alu_pipe #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_udf(out_udf),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .sticky_udf(sticky_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: true lane result in 66-bit signed arithmetic, compared against the lane range.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [1:0] mode, input logic sub,
                                 input logic sgn, input logic sat);
    exp_t               e;
    int                 w;
    logic [63:0]        ra;
    logic [63:0]        rb;
    logic signed [65:0] av;
    logic signed [65:0] bv;
    logic signed [65:0] r;
    logic signed [65:0] mx;
    logic signed [65:0] mn;
    logic signed [65:0] res;
    logic               o;
    logic               u;
    e = '0;
    w = 8 << mode;
    for (int k = 0; k < DW / w; k++) begin
      ra = 64'd0;
      rb = 64'd0;
      for (int j = 0; j < w; j++) begin
        ra[j] = a[k*w+j];
        rb[j] = b[k*w+j];
      end
      av = $signed({2'b00, ra});
      bv = $signed({2'b00, rb});
      if (sgn && ra[w-1]) av = av - (66'sd1 <<< w);
      if (sgn && rb[w-1]) bv = bv - (66'sd1 <<< w);
      r  = sub ? av - bv : av + bv;
      mx = sgn ? (66'sd1 <<< (w-1)) - 66'sd1 : (66'sd1 <<< w) - 66'sd1;
      mn = sgn ? -(66'sd1 <<< (w-1)) : 66'sd0;
      o  = (r > mx);
      u  = (r < mn);
      res = (sat && o) ? mx : ((sat && u) ? mn : r);
      for (int j = 0; j < w; j++) e.data[k*w+j] = res[j];
      for (int j = 0; j < w / 8; j++) begin
        e.ovf[k*(w/8)+j] = o;
        e.udf[k*(w/8)+j] = u;
      end
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // One clock: scoreboard compare/push at the falling edge, then return #1 after the rising edge.
  task automatic step(output bit accepted);
    exp_t e;
    @(negedge clk);
    accepted = in_valid && in_ready && rst_n;
    if (out_valid && out_ready && rst_n) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got data %h, expected no beat", out_data);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_ovf !== e.ovf || out_udf !== e.udf) begin
          n_fail++;
          $display("FAIL scoreboard: got %h ovf %h udf %h, expected %h ovf %h udf %h",
                   out_data, out_ovf, out_udf, e.data, e.ovf, e.udf);
        end
      end
    end
    if (accepted) sb.push_back(model(in_a, in_b, in_mode, in_sub, in_signed, in_sat));
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit acc;
    step(acc);
  endtask

  task automatic set_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [1:0] mode, input logic sub,
                          input logic sgn, input logic sat);
    in_a = a; in_b = b; in_mode = mode;
    in_sub = sub; in_signed = sgn; in_sat = sat;
    in_valid = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() > 0; c++) tick();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++;
    if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    n_tests++;
    if (out_ovf !== '0 || out_udf !== '0) begin
      n_fail++; $display("FAIL rst_flags: got ovf %h udf %h expected 0", out_ovf, out_udf);
    end
    n_tests++;
    if (sticky_ovf !== '0 || sticky_udf !== '0) begin
      n_fail++; $display("FAIL rst_sticky: got %h/%h expected 0", sticky_ovf, sticky_udf);
    end
    rst_n = 1'b1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    sb.delete();
  endtask

  task automatic test_wrap_byte();
    out_ready = 1'b1;
    set_beat({NB{8'hFF}}, {NB{8'h01}}, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got out_valid %b expected 0", out_valid); end
    tick();
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_two: got out_valid %b expected 1", out_valid); end
    n_tests++;
    if (out_data !== '0 || out_ovf !== {NB{1'b1}} || out_udf !== '0) begin
      n_fail++;
      $display("FAIL wrap8: got %h ovf %h udf %h, expected 0 ovf all-ones udf 0", out_data, out_ovf, out_udf);
    end
    drain();
  endtask

  task automatic test_sat16();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] ed;
    a = '0; b = '0; ed = '0;
    a[15:0] = 16'h7FFF; b[15:0] = 16'h0001;
    a[31:16] = 16'h8000; b[31:16] = 16'hFFFF;
    ed[15:0] = 16'h7FFF; ed[31:16] = 16'h8000;
    set_beat(a, b, 2'd1, 1'b0, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_data !== ed || out_ovf !== 32'h0000_0003 || out_udf !== 32'h0000_000C) begin
      n_fail++;
      $display("FAIL sat16: got %h ovf %h udf %h, expected %h ovf 3 udf c", out_data, out_ovf, out_udf, ed);
    end
    drain();
  endtask

  task automatic test_sub64();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] ed;
    a = '0; b = '0; ed = '0;
    a[63:0] = 64'd5; b[63:0] = 64'd7;
    set_beat(a, b, 2'd3, 1'b1, 1'b0, 1'b1);
    tick();
    set_beat(a, b, 2'd3, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_data !== '0 || out_udf !== 32'h0000_00FF || out_ovf !== '0) begin
      n_fail++;
      $display("FAIL sub64_sat: got %h udf %h ovf %h, expected 0 udf ff ovf 0", out_data, out_udf, out_ovf);
    end
    tick();
    ed[63:0] = 64'hFFFF_FFFF_FFFF_FFFE;
    n_tests++;
    if (out_data !== ed || out_udf !== 32'h0000_00FF || out_ovf !== '0) begin
      n_fail++;
      $display("FAIL sub64_wrap: got %h udf %h, expected %h udf ff", out_data, out_udf, ed);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] va[6];
    logic [DW-1:0] vb[6];
    logic [4:0]    ctl[6];
    int            idx;
    bit            acc;
    for (int i = 0; i < 6; i++) begin
      va[i] = rand_vec(); vb[i] = rand_vec(); ctl[i] = 5'($urandom);
    end
    idx = 0;
    for (int cyc = 0; cyc < 60 && (idx < 6 || sb.size() > 0); cyc++) begin
      out_ready = (cyc >= 4);
      if (idx < 6) set_beat(va[idx], vb[idx], ctl[idx][1:0], ctl[idx][2], ctl[idx][3], ctl[idx][4]);
      else in_valid = 1'b0;
      #1;
      if (cyc == 2 || cyc == 3) begin
        n_tests++;
        if (in_ready !== 1'b0 || idx != 2) begin
          n_fail++; $display("FAIL bp_ready: got in_ready %b accepted %0d, expected 0 and 2", in_ready, idx);
        end
        n_tests++;
        if (sb.size() == 0 || out_valid !== 1'b1 || out_data !== sb[0].data) begin
          n_fail++; $display("FAIL bp_hold: got valid %b data %h during stall", out_valid, out_data);
        end
      end
      step(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (idx != 6 || sb.size() != 0) begin
      n_fail++; $display("FAIL bp_complete: got %0d accepted %0d pending, expected 6 and 0", idx, sb.size());
    end
    tick();
    tick();
  endtask

  task automatic test_sticky();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    out_ready = 1'b1;
    in_valid = 1'b0;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    n_tests++;
    if (sticky_ovf !== '0 || sticky_udf !== '0) begin
      n_fail++; $display("FAIL sticky_clear: got %h/%h expected 0/0", sticky_ovf, sticky_udf);
    end
    a = '0; b = '0; a[7:0] = 8'hFF; b[7:0] = 8'h01;
    set_beat(a, b, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    set_beat('0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    b = '0; b[47:40] = 8'h01;
    set_beat('0, b, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (sticky_ovf !== 32'h0000_0001 || sticky_udf !== '0) begin
      n_fail++; $display("FAIL sticky_accum: got %h/%h expected 1/0", sticky_ovf, sticky_udf);
    end
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    n_tests++;
    if (sticky_ovf !== '0 || sticky_udf !== 32'h0000_0020) begin
      n_fail++; $display("FAIL sticky_clr_hs: got %h/%h expected 0/20", sticky_ovf, sticky_udf);
    end
    drain();
  endtask

  task automatic test_mixed_reset();
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      set_beat(rand_vec(), rand_vec(), 2'(m), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (sb.size() != 2) begin
      n_fail++; $display("FAIL mixed_inflight: got %0d pending expected 2", sb.size());
    end
    rst_n = 1'b0;
    tick();
    sb.delete();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL midrst_state: got valid %b data %h expected 0", out_valid, out_data);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_flush: got out_valid %b expected 0", out_valid);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_mode = 2'd0;
    in_sub = 1'b0;
    in_signed = 1'b0;
    in_sat = 1'b0;
    out_ready = 1'b0;
    clr_sticky = 1'b0;
    test_reset();
    test_wrap_byte();
    test_sat16();
    test_sub64();
    test_backpressure();
    test_sticky();
    test_mixed_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
